// File: rtl/uart_tx_sched.sv
// ---------------------------------------------------------------------------
// uart_tx_sched
//
// Transmit scheduler that sits in front of the UART transmitter, in the TX
// clock domain. Two requesters compete for the transmitter: a 2*WIDTH-bit
// ALU result and a WIDTH-bit register-file byte. The accepted word is split
// into bytes (low byte first) and each byte is issued with a one-cycle
// tx_data_valid_out pulse. Parity settings are latched per word so the frame
// format cannot change in the middle of a word.
//
// Handshakes:
//   Requester side: strict valid/ready. A word transfers on a rising clk edge
//   where valid=1 and ready=1. Ready is combinational, is only ever offered in
//   IDLE, never to both sources at once, and does not depend on anything the
//   requester cannot see. Valid may drop before acceptance; nothing is taken.
//   Transmitter side: tx_data_valid_out pulses for one cycle per issue. The
//   transmitter acknowledges by raising tx_busy_in; the byte is complete when
//   tx_busy_in falls again. If tx_busy_in never rises within BUSY_TIMEOUT
//   cycles the same byte is re-issued, without limit.
//
// Ports:
//   clk, reset               clock, asynchronous active-high reset
//   alu_valid_in/_data_in    ALU word request (2*WIDTH bits)
//   alu_ready_out            ALU word accepted when valid & ready
//   rf_valid_in/_data_in     register-file byte request (WIDTH bits)
//   rf_ready_out             rf byte accepted when valid & ready
//   cfg_par_en_in/_type_in   parity config, sampled at accept
//   tx_busy_in               transmitter busy
//   tx_data_out              byte presented to the transmitter (registered)
//   tx_data_valid_out        one-cycle issue pulse
//   tx_par_en_out/_type_out  parity config latched for the current word
//   sched_busy_out           high whenever the FSM is not IDLE
//   dbg_state                current FSM state (IDLE/LOAD/WAIT_BUSY/WAIT_DONE)
// ---------------------------------------------------------------------------
module uart_tx_sched #(
  parameter int WIDTH        = 8,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               alu_valid_in,
  input  logic [2*WIDTH-1:0] alu_data_in,
  output logic               alu_ready_out,
  input  logic               rf_valid_in,
  input  logic [WIDTH-1:0]   rf_data_in,
  output logic               rf_ready_out,
  input  logic               cfg_par_en_in,
  input  logic               cfg_par_type_in,
  input  logic               tx_busy_in,
  output logic [WIDTH-1:0]   tx_data_out,
  output logic               tx_data_valid_out,
  output logic               tx_par_en_out,
  output logic               tx_par_type_out,
  output logic               sched_busy_out,
  output logic [1:0]         dbg_state
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] LOAD      = 2'd1;
  localparam logic [1:0] WAIT_BUSY = 2'd2;
  localparam logic [1:0] WAIT_DONE = 2'd3;

  localparam int TW = (BUSY_TIMEOUT < 2) ? 1 : $clog2(BUSY_TIMEOUT + 1);
  // Counter starts at 0 on the first WAIT_BUSY cycle, so the re-issue
  // decision is taken when it holds BUSY_TIMEOUT-1: that is the
  // BUSY_TIMEOUT-th cycle without busy, and LOAD follows one cycle later.
  localparam logic [TW-1:0] TO_LAST = TW'(BUSY_TIMEOUT - 1);

  logic [1:0]         state;
  logic [2*WIDTH-1:0] hold_buf;     // low byte is the byte on the wire
  logic [1:0]         bytes_rem;
  logic [TW-1:0]      timeout_cnt;
  logic               prefer_rf;    // 0: ALU wins a tie, 1: rf wins a tie
  logic               grant_alu;
  logic               grant_rf;
  logic               accept_alu;
  logic               accept_rf;

  // -------------------------------------------------------------------------
  // Round-robin grant. Only one source can be granted; readies are offered in
  // IDLE only and are forced low while reset is asserted so every output is 0
  // during reset regardless of requester activity.
  // -------------------------------------------------------------------------
  always_comb begin
    grant_alu = 1'b0;
    grant_rf  = 1'b0;
    if (alu_valid_in && rf_valid_in) begin
      grant_alu = !prefer_rf;
      grant_rf  = prefer_rf;
    end else begin
      grant_alu = alu_valid_in;
      grant_rf  = rf_valid_in;
    end
  end

  assign alu_ready_out = !reset && (state == IDLE) && grant_alu;
  assign rf_ready_out  = !reset && (state == IDLE) && grant_rf;
  assign accept_alu    = alu_valid_in && alu_ready_out;
  assign accept_rf     = rf_valid_in && rf_ready_out;

  // The outgoing byte is always the low byte of the holding buffer. Advancing
  // to the next byte shifts the buffer right, so tx_data_out stays stable
  // from LOAD until the byte completes and is never cleared between bytes.
  assign tx_data_out       = hold_buf[WIDTH-1:0];
  assign tx_data_valid_out = (state == LOAD);
  assign sched_busy_out    = (state != IDLE);
  assign dbg_state         = state;

  // -------------------------------------------------------------------------
  // Scheduler FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      hold_buf        <= '0;
      bytes_rem       <= 2'd0;
      timeout_cnt     <= '0;
      prefer_rf       <= 1'b0;
      tx_par_en_out   <= 1'b0;
      tx_par_type_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Busy from the transmitter is deliberately ignored here; the
          // byte-completion handshake in WAIT_DONE is what paces issue.
          if (accept_alu) begin
            hold_buf        <= alu_data_in;
            bytes_rem       <= 2'd2;
            tx_par_en_out   <= cfg_par_en_in;
            tx_par_type_out <= cfg_par_type_in;
            prefer_rf       <= 1'b1;
            state           <= LOAD;
          end else if (accept_rf) begin
            hold_buf        <= {{WIDTH{1'b0}}, rf_data_in};
            bytes_rem       <= 2'd1;
            tx_par_en_out   <= cfg_par_en_in;
            tx_par_type_out <= cfg_par_type_in;
            prefer_rf       <= 1'b0;
            state           <= LOAD;
          end
        end

        LOAD: begin
          timeout_cnt <= '0;
          state       <= WAIT_BUSY;
        end

        WAIT_BUSY: begin
          if (tx_busy_in) begin
            state <= WAIT_DONE;
          end else if (timeout_cnt == TO_LAST) begin
            // Transmitter missed the pulse: re-issue the same byte.
            state <= LOAD;
          end else begin
            timeout_cnt <= timeout_cnt + 1'b1;
          end
        end

        WAIT_DONE: begin
          if (!tx_busy_in) begin
            bytes_rem <= bytes_rem - 2'd1;
            if (bytes_rem != 2'd1) begin
              hold_buf <= {{WIDTH{1'b0}}, hold_buf[2*WIDTH-1:WIDTH]};
              state    <= LOAD;
            end else begin
              state <= IDLE;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_sched
//
// Directed bench for uart_tx_sched (WIDTH=8, BUSY_TIMEOUT=4). Inputs are
// driven 2 time units after each rising edge; outputs are sampled in the
// same window, after combinational ready has settled.
// ---------------------------------------------------------------------------
module tb_uart_tx_sched;

  localparam int WIDTH        = 8;
  localparam int BUSY_TIMEOUT = 4;

  // Clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic               alu_valid_in;
  logic [2*WIDTH-1:0] alu_data_in;
  logic               alu_ready_out;
  logic               rf_valid_in;
  logic [WIDTH-1:0]   rf_data_in;
  logic               rf_ready_out;
  logic               cfg_par_en_in;
  logic               cfg_par_type_in;
  logic               tx_busy_in;
  logic [WIDTH-1:0]   tx_data_out;
  logic               tx_data_valid_out;
  logic               tx_par_en_out;
  logic               tx_par_type_out;
  logic               sched_busy_out;
  logic [1:0]         dbg_state;

  uart_tx_sched #(
    .WIDTH        (WIDTH),
    .BUSY_TIMEOUT (BUSY_TIMEOUT)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .alu_valid_in      (alu_valid_in),
    .alu_data_in       (alu_data_in),
    .alu_ready_out     (alu_ready_out),
    .rf_valid_in       (rf_valid_in),
    .rf_data_in        (rf_data_in),
    .rf_ready_out      (rf_ready_out),
    .cfg_par_en_in     (cfg_par_en_in),
    .cfg_par_type_in   (cfg_par_type_in),
    .tx_busy_in        (tx_busy_in),
    .tx_data_out       (tx_data_out),
    .tx_data_valid_out (tx_data_valid_out),
    .tx_par_en_out     (tx_par_en_out),
    .tx_par_type_out   (tx_par_type_out),
    .sched_busy_out    (sched_busy_out),
    .dbg_state         (dbg_state)
  );

  int checks = 0;
  int errors = 0;

  // Scoreboard of bytes the transmitter must see, in order.
  logic [WIDTH-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Check the grant in the current IDLE cycle, then let the accept edge pass.
  task automatic accept(input string tag, input bit exp_alu);
    #1;
    chk({tag, "_alu_ready"}, {31'd0, alu_ready_out}, {31'd0, exp_alu});
    chk({tag, "_rf_ready"}, {31'd0, rf_ready_out}, {31'd0, !exp_alu});
    step();
  endtask

  // Bounded wait for the issue pulse; an expired bound fails the check.
  task automatic wait_pulse(input string tag);
    for (int i = 0; i < 20; i++) begin
      if (tx_data_valid_out) break;
      step();
    end
    chk({tag, "_pulse"}, {31'd0, tx_data_valid_out}, 32'd1);
  endtask

  // Transmitter model: busy rises one cycle after the pulse, held len cycles.
  task automatic busy_phase(input string tag, input int len);
    step();
    chk({tag, "_pulse_width"}, {31'd0, tx_data_valid_out}, 32'd0);
    tx_busy_in = 1'b1;
    repeat (len) step();
    chk({tag, "_sched_busy"}, {31'd0, sched_busy_out}, 32'd1);
    tx_busy_in = 1'b0;
  endtask

  task automatic send_byte(input string tag, input bit pe, input bit pt, input int len);
    logic [WIDTH-1:0] exp_b;
    exp_b = exp_q.pop_front();
    wait_pulse(tag);
    chk({tag, "_data"}, {24'd0, tx_data_out}, {24'd0, exp_b});
    chk({tag, "_par_en"}, {31'd0, tx_par_en_out}, {31'd0, pe});
    chk({tag, "_par_type"}, {31'd0, tx_par_type_out}, {31'd0, pt});
    busy_phase(tag, len);
  endtask

  task automatic finish_idle(input string tag, input logic [WIDTH-1:0] last_b);
    step();
    chk({tag, "_idle_busy"}, {31'd0, sched_busy_out}, 32'd0);
    chk({tag, "_idle_state"}, {30'd0, dbg_state}, 32'd0);
    chk({tag, "_data_held"}, {24'd0, tx_data_out}, {24'd0, last_b});
  endtask

  initial begin
    int gap;

    reset           = 1'b1;
    alu_valid_in    = 1'b0;
    alu_data_in     = '0;
    rf_valid_in     = 1'b0;
    rf_data_in      = '0;
    cfg_par_en_in   = 1'b0;
    cfg_par_type_in = 1'b0;
    tx_busy_in      = 1'b0;

    // ---- Reset state ----
    step();
    step();
    chk("rst_state", {30'd0, dbg_state}, 32'd0);
    chk("rst_data", {24'd0, tx_data_out}, 32'd0);
    chk("rst_valid", {31'd0, tx_data_valid_out}, 32'd0);
    chk("rst_par_en", {31'd0, tx_par_en_out}, 32'd0);
    chk("rst_par_type", {31'd0, tx_par_type_out}, 32'd0);
    chk("rst_sched_busy", {31'd0, sched_busy_out}, 32'd0);
    chk("rst_alu_ready", {31'd0, alu_ready_out}, 32'd0);
    chk("rst_rf_ready", {31'd0, rf_ready_out}, 32'd0);
    reset = 1'b0;
    step();

    // ---- 1: ALU only, 16'hA55A, parity odd enabled ----
    alu_valid_in = 1'b1; alu_data_in = 16'hA55A;
    cfg_par_en_in = 1'b1; cfg_par_type_in = 1'b1;
    exp_q.push_back(8'h5A); exp_q.push_back(8'hA5);
    accept("t1", 1'b1);
    chk("t1_latency", {31'd0, tx_data_valid_out}, 32'd1);
    alu_valid_in = 1'b0;
    send_byte("t1_b0", 1'b1, 1'b1, 11);
    send_byte("t1_b1", 1'b1, 1'b1, 11);
    finish_idle("t1", 8'hA5);

    // ---- 2: rf only, 8'h3C ----
    rf_valid_in = 1'b1; rf_data_in = 8'h3C;
    cfg_par_en_in = 1'b0; cfg_par_type_in = 1'b0;
    exp_q.push_back(8'h3C);
    accept("t2", 1'b0);
    rf_valid_in = 1'b0;
    #1;
    chk("t2_rf_ready_drop", {31'd0, rf_ready_out}, 32'd0);
    send_byte("t2_b0", 1'b0, 1'b0, 3);
    finish_idle("t2", 8'h3C);

    // ---- 3: both valid continuously, round-robin ALU, rf, ALU, rf ----
    alu_valid_in = 1'b1; alu_data_in = 16'h1234;
    rf_valid_in  = 1'b1; rf_data_in  = 8'h77;
    for (int r = 0; r < 2; r++) begin
      exp_q.push_back(8'h34); exp_q.push_back(8'h12);
      accept("t3_alu", 1'b1);
      send_byte("t3_alu_b0", 1'b0, 1'b0, 2);
      send_byte("t3_alu_b1", 1'b0, 1'b0, 2);
      finish_idle("t3_alu", 8'h12);
      exp_q.push_back(8'h77);
      accept("t3_rf", 1'b0);
      send_byte("t3_rf_b0", 1'b0, 1'b0, 2);
      finish_idle("t3_rf", 8'h77);
    end
    alu_valid_in = 1'b0;
    rf_valid_in  = 1'b0;

    // ---- 4: first pulse ignored -> re-issue after BUSY_TIMEOUT+1 cycles ----
    alu_valid_in = 1'b1; alu_data_in = 16'h0F81;
    cfg_par_en_in = 1'b1; cfg_par_type_in = 1'b0;
    accept("t4", 1'b1);
    alu_valid_in = 1'b0;
    wait_pulse("t4_first");
    chk("t4_first_data", {24'd0, tx_data_out}, 32'h81);
    gap = 0;
    do begin
      step();
      gap++;
    end while (!tx_data_valid_out && gap < 20);
    chk("t4_reissue_gap", gap, BUSY_TIMEOUT + 1);
    chk("t4_reissue_data", {24'd0, tx_data_out}, 32'h81);
    busy_phase("t4_b0", 5);
    exp_q.push_back(8'h0F);
    send_byte("t4_b1", 1'b1, 1'b0, 5);
    finish_idle("t4", 8'h0F);

    // ---- 5: cfg change mid-word ignored until next accept ----
    alu_valid_in = 1'b1; alu_data_in = 16'hBEEF;
    cfg_par_en_in = 1'b0; cfg_par_type_in = 1'b0;
    exp_q.push_back(8'hEF); exp_q.push_back(8'hBE);
    accept("t5", 1'b1);
    alu_valid_in = 1'b0;
    cfg_par_en_in = 1'b1; cfg_par_type_in = 1'b1;
    send_byte("t5_b0", 1'b0, 1'b0, 4);
    send_byte("t5_b1", 1'b0, 1'b0, 4);
    finish_idle("t5", 8'hBE);
    chk("t5_par_en_hold", {31'd0, tx_par_en_out}, 32'd0);
    rf_valid_in = 1'b1; rf_data_in = 8'h11;
    exp_q.push_back(8'h11);
    accept("t5_next", 1'b0);
    rf_valid_in = 1'b0;
    chk("t5_next_par_en", {31'd0, tx_par_en_out}, 32'd1);
    chk("t5_next_par_type", {31'd0, tx_par_type_out}, 32'd1);
    send_byte("t5_next_b0", 1'b1, 1'b1, 2);
    finish_idle("t5_next", 8'h11);

    // ---- 6: reset during WAIT_DONE of first ALU byte ----
    alu_valid_in = 1'b1; alu_data_in = 16'h5566;
    accept("t6", 1'b1);
    alu_valid_in = 1'b0;
    wait_pulse("t6_b0");
    chk("t6_b0_data", {24'd0, tx_data_out}, 32'h66);
    step();
    tx_busy_in = 1'b1;
    step();
    step();
    chk("t6_in_wait_done", {30'd0, dbg_state}, 32'd3);
    alu_valid_in = 1'b1; alu_data_in = 16'h7788;
    rf_valid_in  = 1'b1; rf_data_in  = 8'h99;
    reset = 1'b1;
    #1;
    chk("t6_rst_state", {30'd0, dbg_state}, 32'd0);
    chk("t6_rst_data", {24'd0, tx_data_out}, 32'd0);
    chk("t6_rst_valid", {31'd0, tx_data_valid_out}, 32'd0);
    chk("t6_rst_par_en", {31'd0, tx_par_en_out}, 32'd0);
    chk("t6_rst_par_type", {31'd0, tx_par_type_out}, 32'd0);
    chk("t6_rst_sched_busy", {31'd0, sched_busy_out}, 32'd0);
    chk("t6_rst_alu_ready", {31'd0, alu_ready_out}, 32'd0);
    chk("t6_rst_rf_ready", {31'd0, rf_ready_out}, 32'd0);
    tx_busy_in = 1'b0;
    step();
    reset = 1'b0;
    // Pointer is back to ALU even though ALU was served last before reset;
    // the first byte after reset is 88, never the aborted word's 55.
    exp_q.push_back(8'h88); exp_q.push_back(8'h77);
    accept("t6_after", 1'b1);
    alu_valid_in = 1'b0;
    rf_valid_in  = 1'b0;
    send_byte("t6_after_b0", 1'b1, 1'b1, 3);
    send_byte("t6_after_b1", 1'b1, 1'b1, 3);
    finish_idle("t6_after", 8'h77);
    chk("exp_q_drained", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
